dpe_egress_demux: RTL and testbench
===================================

Name: dpe_egress_demux

Overview:
- Egress end of the DPE pipeline. Consumes the single switched AXI-Stream that carries a tuser_dst routing tag, and steers each packet whole to one of NUM_PORTS per-destination output streams.
- Output ports feed the To-CPU and To-ETH_1..4 FIFOs.
- Routing is locked per packet on its first beat. Packets with an unroutable destination are drained and counted.
- One registered output stage per port gives full-throughput, 1-cycle-latency forwarding.

Parameters:
- DATA_W, 128, tdata width in bits.
- KEEP_W, DATA_W/8, tkeep width.
- ADDR_W, 3, width of tuser_src/tuser_dst (dpe_pkg address encoding).
- NUM_PORTS, 5, number of egress ports. Index 0=CPU, 1=ETH_1, 2=ETH_2, 3=ETH_3, 4=ETH_4 (dpe_pkg DPE_ADDR_* values equal these indices).
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- s_tvalid  in  1  input stream valid.
- s_tready  out  1  input stream ready.
- s_tdata  in  DATA_W  input data.
- s_tkeep  in  KEEP_W  input byte enables.
- s_tlast  in  1  last beat of packet.
- s_tuser_src  in  ADDR_W  source address; passed through.
- s_tuser_dst  in  ADDR_W  destination address; sampled on first beat only.
- m_tvalid  out  NUM_PORTS  per-port valid.
- m_tready  in  NUM_PORTS  per-port ready.
- m_tdata  out  NUM_PORTS*DATA_W  per-port data; slice p belongs to port p.
- m_tkeep  out  NUM_PORTS*KEEP_W  per-port keep.
- m_tlast  out  NUM_PORTS  per-port last.
- m_tuser_src  out  NUM_PORTS*ADDR_W  per-port source tag.
- drop_cnt  out  CNT_W  count of dropped packets; saturating.

Behaviour:
- Reset (rst=0 at a clock edge):
  - m_tvalid=0, all m_* data registers=0.
  - State goes to IDLE, drop_cnt=0.
  - s_tready=0 during reset.
  - Reset mid-packet truncates that packet silently. No tlast is synthesized, and the remainder of the input packet after reset is treated as a new packet.
- States:
  - IDLE: awaiting first beat.
  - FWD: mid-packet, routed to locked port sel_q.
  - DROP: mid-packet, discarding.
- First-beat port selection (IDLE):
  - sel = s_tuser_dst.
  - valid_dst = (s_tuser_dst < NUM_PORTS).
- s_tready:
  - IDLE with valid_dst, and FWD: s_tready = !m_tvalid[sel] | m_tready[sel]. sel is the combinational sel in IDLE and sel_q in FWD.
  - IDLE with !valid_dst, and DROP: s_tready = 1.
  - s_tready never depends on any other port's ready.
- Accepted beat (s_tvalid & s_tready), forwarding case:
  - Next cycle: m_tvalid[sel]=1 and port sel's registers load tdata/tkeep/tlast/tuser_src.
  - Latency is exactly 1 cycle.
  - Simultaneous drain and load on the same port in one cycle is required, so a continuously ready sink sees 1 beat per clock.
- Output hold: a port register with m_tvalid=1 and m_tready=0 holds all fields stable. m_tvalid clears only on m_tready with no new load.
- Transitions:
  - IDLE: accepted beat with tlast stays IDLE (single-beat packet). Without tlast, go to FWD (latch sel_q) if valid_dst, else DROP.
  - FWD: accepted beat with tlast goes to IDLE.
  - DROP: accepted beat with tlast goes to IDLE.
  - s_tuser_dst changes mid-packet are ignored.
- drop_cnt: increments by 1 on the first beat of each dropped packet (including single-beat drops). It saturates at 2^CNT_W-1 and does not wrap.
- Ports other than the locked one keep draining independently while a packet is stalled.
- tkeep=0 beats are forwarded unchanged; no filtering is done.

Test Plan:
- Single-beat packets to dst 0,1,2,3,4 back-to-back, all m_tready=1. Expect each beat on the matching port exactly 1 cycle later with identical tdata/tkeep/tuser_src, and s_tready constantly 1.
- 4-beat packet, first beat dst=1, later beats dst=3. All 4 beats go to port 1, tlast only on beat 4, and port 3 sees nothing.
- 3-beat packet to port 2 with m_tready[2]=0 for 5 cycles after beat 1:
  - s_tready drops to 0 while port 2 holds beat 1 stable.
  - On release, beats 2 and 3 arrive on consecutive cycles.
  - Meanwhile a value already in port 4's register drains under m_tready[4]=1.
- Packets with dst=5, 6 and 7 (2-beat, 1-beat, 3-beat). All are accepted at 1 beat/cycle with no m_tvalid asserted, and drop_cnt=3.
- drop_cnt forced near saturation (CNT_W=4): 17 dropped packets give drop_cnt=15.
- rst=0 asserted on beat 2 of a 4-beat packet to port 1:
  - Next cycle m_tvalid=0 and drop_cnt=0.
  - After release, the residual beats 3 and 4 are treated as a new packet routed by beat 3's tuser_dst.

Source files
------------

// File: rtl/dpe_egress_demux_if.sv
// Stream bundle between the DPE switch core and the egress FIFOs.
// The slave modport is the demux's view; master is the view of whatever drives it.
interface dpe_egress_demux_if #(
  parameter int DATA_W    = 128,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int ADDR_W    = 3,
  parameter int NUM_PORTS = 5
);
  logic                          s_tvalid;
  logic                          s_tready;
  logic [DATA_W-1:0]             s_tdata;
  logic [KEEP_W-1:0]             s_tkeep;
  logic                          s_tlast;
  logic [ADDR_W-1:0]             s_tuser_src;
  logic [ADDR_W-1:0]             s_tuser_dst;
  logic [NUM_PORTS-1:0]          m_tvalid;
  logic [NUM_PORTS-1:0]          m_tready;
  logic [NUM_PORTS*DATA_W-1:0]   m_tdata;
  logic [NUM_PORTS*KEEP_W-1:0]   m_tkeep;
  logic [NUM_PORTS-1:0]          m_tlast;
  logic [NUM_PORTS*ADDR_W-1:0]   m_tuser_src;

  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser_src, s_tuser_dst, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser_src
  );

  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser_src, s_tuser_dst, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser_src
  );
endinterface

// File: rtl/dpe_egress_demux.sv
// Egress demux: steers each whole packet from the switched stream to its destination port.
//   state | meaning
//   IDLE  | awaiting first beat of a packet
//   FWD   | mid-packet, beats go to locked port sel_q
//   DROP  | mid-packet, unroutable destination, beats discarded
module dpe_egress_demux #(
  parameter int DATA_W    = 128,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int ADDR_W    = 3,
  parameter int NUM_PORTS = 5,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  dpe_egress_demux_if.slave bus,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    sel_q;
  logic [ADDR_W-1:0]    sel;
  logic                 valid_dst;
  logic                 fwd_path;
  logic                 accept;
  logic                 first_drop;
  logic [NUM_PORTS-1:0] port_hit;
  logic [NUM_PORTS-1:0] load;

  assign valid_dst = ({1'b0, bus.s_tuser_dst} < (ADDR_W+1)'(NUM_PORTS));
  assign sel       = (state_q == IDLE) ? bus.s_tuser_dst : sel_q;
  assign accept    = bus.s_tvalid & bus.s_tready;
  assign load      = accept ? port_hit : '0;

  // Ready looks only at the selected port so a stalled sink never blocks the others.
  always_comb begin
    fwd_path = (state_q == FWD) || ((state_q == IDLE) && valid_dst);
    port_hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_hit[p] = fwd_path && (sel == ADDR_W'(p));
    end
    if (!rst) begin
      bus.s_tready = 1'b0;
    end else if (fwd_path) begin
      bus.s_tready = |(port_hit & (~bus.m_tvalid | bus.m_tready));
    end else begin
      bus.s_tready = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    first_drop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          first_drop = !valid_dst;
          if (!bus.s_tlast) state_d = valid_dst ? FWD : DROP;
        end
      end
      FWD, DROP: begin
        if (accept && bus.s_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && accept) sel_q <= bus.s_tuser_dst;
      if (first_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // A load wins over a drain so a continuously ready sink takes one beat per clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.m_tvalid    <= '0;
      bus.m_tdata     <= '0;
      bus.m_tkeep     <= '0;
      bus.m_tlast     <= '0;
      bus.m_tuser_src <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (load[p]) begin
          bus.m_tvalid[p]                        <= 1'b1;
          bus.m_tdata[p*DATA_W +: DATA_W]        <= bus.s_tdata;
          bus.m_tkeep[p*KEEP_W +: KEEP_W]        <= bus.s_tkeep;
          bus.m_tlast[p]                         <= bus.s_tlast;
          bus.m_tuser_src[p*ADDR_W +: ADDR_W]    <= bus.s_tuser_src;
        end else if (bus.m_tready[p]) begin
          bus.m_tvalid[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpe_egress_demux.sv
// Bench for dpe_egress_demux: directed scenarios plus random traffic against a packet-level model.
module tb_dpe_egress_demux;
  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int ADDR_W = 3;
  localparam int NP     = 5;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] drop_cnt;

  dpe_egress_demux_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .ADDR_W(ADDR_W), .NUM_PORTS(NP)) bus ();

  dpe_egress_demux #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ADDR_W(ADDR_W), .NUM_PORTS(NP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Packet-level model: what each port register must hold, which packet is open, and drop total.
  bit                mv[NP];
  logic [DATA_W-1:0] md[NP];
  logic [KEEP_W-1:0] mk[NP];
  bit                ml[NP];
  logic [ADDR_W-1:0] ms[NP];
  bit                pkt_open;
  int                pkt_dst;
  int                drops;
  bit                started = 1'b0;
  int                d;
  bit                er;
  bit                acc;

  initial forever begin
    @(negedge clk);
    d  = pkt_open ? pkt_dst : int'(bus.s_tuser_dst);
    er = (rst !== 1'b0) && ((d >= NP) || !mv[d] || (bus.m_tready[d] === 1'b1));
    if (started) begin
      chk("s_tready", {127'd0, bus.s_tready}, {127'd0, er});
      chk("drop_cnt", {124'd0, drop_cnt}, DATA_W'(drops));
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("m_tvalid[%0d]", p), {127'd0, bus.m_tvalid[p]}, {127'd0, mv[p]});
        if (mv[p]) begin
          chk($sformatf("m_tdata[%0d]", p), bus.m_tdata[p*DATA_W +: DATA_W], md[p]);
          chk($sformatf("m_tkeep[%0d]", p), {112'd0, bus.m_tkeep[p*KEEP_W +: KEEP_W]}, {112'd0, mk[p]});
          chk($sformatf("m_tlast[%0d]", p), {127'd0, bus.m_tlast[p]}, {127'd0, ml[p]});
          chk($sformatf("m_tuser_src[%0d]", p), {125'd0, bus.m_tuser_src[p*ADDR_W +: ADDR_W]}, {125'd0, ms[p]});
        end
      end
    end
    if (rst === 1'b0) begin
      for (int p = 0; p < NP; p++) mv[p] = 1'b0;
      pkt_open = 1'b0;
      pkt_dst  = 0;
      drops    = 0;
      started  = 1'b1;
    end else if (started) begin
      acc = bus.s_tvalid && er;
      for (int p = 0; p < NP; p++) begin
        if (acc && d == p) begin
          mv[p] = 1'b1;
          md[p] = bus.s_tdata;
          mk[p] = bus.s_tkeep;
          ml[p] = bus.s_tlast;
          ms[p] = bus.s_tuser_src;
        end else if (bus.m_tready[p]) begin
          mv[p] = 1'b0;
        end
      end
      if (acc) begin
        if (!pkt_open && d >= NP && drops < SAT) drops++;
        pkt_open = !bus.s_tlast;
        pkt_dst  = d;
      end
    end
  end

  bit           rand_rdy  = 1'b0;
  logic [NP-1:0] rdy_force = '1;

  initial forever begin
    @(posedge clk);
    #1;
    bus.m_tready = rand_rdy ? NP'($urandom) : rdy_force;
  end

  task automatic send(input logic [ADDR_W-1:0] dst, input bit last, input logic [DATA_W-1:0] data,
                      input logic [KEEP_W-1:0] keep, input logic [ADDR_W-1:0] src);
    int  n    = 0;
    bit  done = 1'b0;
    bus.s_tvalid    = 1'b1;
    bus.s_tuser_dst = dst;
    bus.s_tlast     = last;
    bus.s_tdata     = data;
    bus.s_tkeep     = keep;
    bus.s_tuser_src = src;
    while (!done) begin
      @(negedge clk);
      done = (bus.s_tready === 1'b1);
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat to dst %0d not accepted after %0d cycles", dst, n);
        done = 1'b1;
      end
    end
    bus.s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst             = 1'b0;
    bus.s_tvalid    = 1'b0;
    bus.s_tdata     = '0;
    bus.s_tkeep     = '0;
    bus.s_tlast     = 1'b0;
    bus.s_tuser_src = '0;
    bus.s_tuser_dst = '0;
    bus.m_tready    = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_tvalid", {123'd0, bus.m_tvalid}, 128'd0);
    chk("reset_drop_cnt", {124'd0, drop_cnt}, 128'd0);
    rst = 1'b1;

    // Single-beat packets to every port, back to back, one with tkeep=0.
    for (int i = 0; i < NP; i++) begin
      logic [DATA_W-1:0] v;
      v = {4{32'hA000_0000 + 32'(i)}};
      send(ADDR_W'(i), 1'b1, v, (i == 0) ? 16'h0000 : 16'hF0F0 ^ 16'(i), ADDR_W'(7 - i));
    end
    chk("t1_port4_data", bus.m_tdata[4*DATA_W +: DATA_W], {4{32'hA000_0004}});
    chk("t1_port4_src", {125'd0, bus.m_tuser_src[4*ADDR_W +: ADDR_W]}, 128'd3);
    idle(2);

    // Multi-beat packet whose later beats carry a different destination.
    send(3'd1, 1'b0, 128'h11, 16'hFFFF, 3'd2);
    send(3'd3, 1'b0, 128'h12, 16'hFFFF, 3'd2);
    send(3'd3, 1'b0, 128'h13, 16'hFFFF, 3'd2);
    send(3'd3, 1'b1, 128'h14, 16'h00FF, 3'd2);
    chk("t2_port1_last_data", bus.m_tdata[1*DATA_W +: DATA_W], 128'h14);
    chk("t2_port3_idle", {127'd0, bus.m_tvalid[3]}, 128'd0);
    idle(2);

    // Stall on port 2 while port 4 drains independently.
    rdy_force = 5'b00000;
    idle(1);
    send(3'd4, 1'b1, 128'h44, 16'hFFFF, 3'd1);
    send(3'd2, 1'b0, 128'h21, 16'hFFFF, 3'd4);
    fork
      begin
        send(3'd2, 1'b0, 128'h22, 16'hFFFF, 3'd4);
        send(3'd2, 1'b1, 128'h23, 16'h000F, 3'd4);
      end
      begin
        rdy_force = 5'b10000;
        repeat (3) @(negedge clk);
        chk("t3_stall_ready", {127'd0, bus.s_tready}, 128'd0);
        chk("t3_hold_data", bus.m_tdata[2*DATA_W +: DATA_W], 128'h21);
        chk("t3_port4_drained", {127'd0, bus.m_tvalid[4]}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rdy_force = 5'b11111;
      end
    join
    idle(3);

    // Unroutable destinations are swallowed and counted once per packet.
    send(3'd5, 1'b0, rnd_data(), 16'hFFFF, 3'd0);
    send(3'd1, 1'b1, rnd_data(), 16'hFFFF, 3'd0);
    send(3'd6, 1'b1, rnd_data(), 16'hFFFF, 3'd0);
    send(3'd7, 1'b0, rnd_data(), 16'hFFFF, 3'd0);
    send(3'd0, 1'b0, rnd_data(), 16'hFFFF, 3'd0);
    send(3'd2, 1'b1, rnd_data(), 16'hFFFF, 3'd0);
    chk("t4_drop_cnt", {124'd0, drop_cnt}, 128'd3);
    chk("t4_no_valid", {123'd0, bus.m_tvalid}, 128'd0);

    // Saturation of the drop counter.
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(ADDR_W'($urandom_range(5, 7)), 1'b1, rnd_data(), 16'hFFFF, 3'd0);
      if (i == 13) chk("t5_drop_cnt_14", {124'd0, drop_cnt}, 128'd14);
    end
    chk("t5_drop_cnt_sat", {124'd0, drop_cnt}, 128'd15);

    // Reset in the middle of a packet; the tail becomes a new packet.
    send(3'd1, 1'b0, 128'h61, 16'hFFFF, 3'd5);
    bus.s_tvalid    = 1'b1;
    bus.s_tuser_dst = 3'd1;
    bus.s_tlast     = 1'b0;
    bus.s_tdata     = 128'h62;
    rst             = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_reset_valid", {123'd0, bus.m_tvalid}, 128'd0);
    chk("t6_reset_drop", {124'd0, drop_cnt}, 128'd0);
    rst          = 1'b1;
    bus.s_tvalid = 1'b0;
    send(3'd3, 1'b0, 128'h63, 16'hFFFF, 3'd5);
    chk("t6_route_valid", {123'd0, bus.m_tvalid}, 128'h08);
    chk("t6_route_data", bus.m_tdata[3*DATA_W +: DATA_W], 128'h63);
    send(3'd0, 1'b1, 128'h64, 16'hFFFF, 3'd5);
    chk("t6_tail_data", bus.m_tdata[3*DATA_W +: DATA_W], 128'h64);
    idle(2);

    // Random traffic with random sink backpressure.
    rand_rdy = 1'b1;
    for (int pk = 0; pk < 80; pk++) begin
      int len;
      logic [ADDR_W-1:0] dst;
      len = $urandom_range(1, 4);
      dst = ADDR_W'($urandom_range(0, 7));
      for (int b = 0; b < len; b++) begin
        send((b == 0) ? dst : ADDR_W'($urandom), (b == len - 1), rnd_data(), KEEP_W'($urandom),
             ADDR_W'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    rdy_force = '1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
